// File: rtl/spi_note_decoder.sv
// SPI mode-0 note-command receiver, fully oversampled in the i_clk domain.
// Each 48-bit frame becomes a one-cycle command strobe with voice/tuning/status fields.
module spi_note_decoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_spi_sck,
    input  logic        i_spi_mosi,
    input  logic        i_spi_cs_n,
    output logic        o_SPI_flag,
    output logic [7:0]  o_SPI_voice_index,
    output logic [31:0] o_SPI_tuning_code,
    output logic        o_SPI_note_status,
    output logic        o_frame_error,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
    logic        sck_q, cs_q;
    logic        sck_rise, cs_rise, cs_fall, shift_en, frame_ok;
    logic [47:0] shreg;
    logic [5:0]  bit_cnt;

    // CS_N sync resets low so a frame already running at reset release never
    // produces a falling edge and is therefore ignored.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
            sck_q     <= sck_sync[SYNC_STAGES-1];
            cs_q      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_q;
    assign cs_rise  = cs_sync[SYNC_STAGES-1] & ~cs_q;
    assign cs_fall  = ~cs_sync[SYNC_STAGES-1] & cs_q;
    assign shift_en = (state == SHIFT) && sck_rise && !cs_sync[SYNC_STAGES-1];
    assign frame_ok = (bit_cnt == 6'd48) && (shreg[47:41] == 7'd0);
    assign o_busy   = (state == SHIFT);

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = SHIFT;
            SHIFT:   if (cs_rise) state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shreg             <= '0;
            bit_cnt           <= '0;
            o_SPI_flag        <= 1'b0;
            o_frame_error     <= 1'b0;
            o_SPI_voice_index <= '0;
            o_SPI_tuning_code <= '0;
            o_SPI_note_status <= 1'b0;
        end else begin
            o_SPI_flag    <= 1'b0;
            o_frame_error <= 1'b0;
            if (state == IDLE && cs_fall) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end
            if (shift_en) begin
                shreg <= {shreg[46:0], mosi_sync[SYNC_STAGES-1]};
                // Saturate so overlong frames can never wrap back to 48.
                if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
            end
            if (state == CHECK) begin
                if (frame_ok) begin
                    o_SPI_flag        <= 1'b1;
                    o_SPI_note_status <= shreg[40];
                    o_SPI_voice_index <= shreg[39:32];
                    o_SPI_tuning_code <= shreg[31:0];
                end else begin
                    o_frame_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/spi_note_decoder.md
# spi_note_decoder

Receives note commands from the host microcontroller over a mode-0 SPI link and turns each complete frame into the single-cycle command strobe and fields consumed by the voice pipeline: `dds` (tuning code) and `ADSR` (note status). It sits between the SPI pins and the `i_SPI_*` inputs of the voice chain, entirely in the `i_clk` domain. SPI lines are oversampled through synchronizers; no SCK-domain logic exists.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the SCK/MOSI/CS_N synchronizers (minimum 2).
- `i_clk`  in  1  system clock; the same clock as the voice pipeline.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_spi_sck`  in  1  raw SPI clock (asynchronous).
- `i_spi_mosi`  in  1  raw SPI data (asynchronous); MSB first, sampled on SCK rising edge.
- `i_spi_cs_n`  in  1  raw active-low chip select (asynchronous); frames a command.
- `o_SPI_flag`  out  1  one-cycle strobe: a new valid command is on the fields.
- `o_SPI_voice_index`  out  8  target voice.
- `o_SPI_tuning_code`  out  32  DDS phase increment.
- `o_SPI_note_status`  out  1  1 = note on, 0 = note off.
- `o_frame_error`  out  1  one-cycle strobe: the frame was rejected.
- `o_busy`  out  1  high while a frame is being shifted in (state SHIFT).

## Operation
- Frame: exactly 48 bits, MSB first. Byte 0 is the command: 0x01 = note on, 0x00 = note off. Byte 1 is the voice index. Bytes 2–5 are the tuning code, MSB byte first. Note-off frames still carry all 6 bytes; the tuning code is taken from the frame as-is.
- Synchronizers: SCK and MOSI reset to 0. CS_N resets to 0 (treated as asserted), so a frame already in progress at reset release is never accepted. A sync-CS_N high must be seen first.
- Edge detection uses the last sync stage against a 1-cycle-delayed copy.
- FSM:
  - IDLE: on a sync-CS_N falling edge, go to SHIFT, clear the 48-bit shift register and the bit counter.
  - SHIFT: on each sync-SCK rising edge while sync-CS_N is low, shift in sync-MOSI and increment the 6-bit bit counter, saturating at 63. On a sync-CS_N rising edge, go to CHECK.
  - CHECK (1 cycle): the frame is valid iff counter == 48 and byte 0 ∈ {0x00, 0x01}.
    - Valid: load all fields, pulse `o_SPI_flag`.
    - Invalid: pulse `o_frame_error`; fields are unchanged.
    - Next state is always IDLE.
- Fields hold their value between flags, and across errors.
- SCK edges seen outside SHIFT are ignored. A CS_N falling edge in CHECK is not possible, because the minimum CS_N high time is enforced (see Timing).
- Reset: state IDLE; all outputs 0 (`o_SPI_flag`, `o_frame_error`, `o_busy`, and every field); counter and shift register cleared.

## Timing
- Flag latency: let edge 0 be the first `i_clk` edge that samples raw CS_N = 1. `o_SPI_flag` / `o_frame_error` is high for exactly the one cycle following edge `SYNC_STAGES`+1. With the default this is edge 3.
- Fields change on the same edge the flag rises.
- Host constraints, in `i_clk` cycles:
  - SCK high ≥ 3 and SCK low ≥ 3.
  - Last SCK rise ≥ 3 cycles before CS_N rise.
  - First SCK rise ≥ 3 cycles after CS_N fall.
  - CS_N high between frames ≥ 4 cycles.
- MOSI must be stable ≥ 2 cycles either side of each SCK rise.
- Back-to-back frames at the minimum gap produce one flag per frame, with no loss.
- `o_busy` is high from the cycle after the CS_N fall is detected through the cycle before CHECK.

## Test plan
- Note on, voice 5, tuning 20000000 (bytes 01 05 01 31 2D 00) -> one-cycle `o_SPI_flag` at CS_N rise + 3 cycles; fields = 5 / 0x01312D00 / 1; `o_frame_error` stays 0.
- Then a note-off frame for voice 5 with tuning 0 -> flag; note_status 0; voice 5; tuning 0.
- 40-bit frame, and separately a 56-bit frame -> `o_frame_error` pulse only; fields still hold the previous note-on values.
- Command byte 0x7F with a valid length -> `o_frame_error`; no flag.
- `i_reset` asserted at bit 20 of a frame, released while CS_N is still low -> no flag and no error for that frame; the next full frame (voice 9, tuning 0x00000001, on) produces a flag with those values.
- Three back-to-back valid frames, CS_N high for 4 cycles between them, SCK at 3 high / 3 low -> exactly three flags, each with that frame's fields.
